// File: rtl/spi_master_tx_if.sv
// rtl/spi_master_tx_if.sv - control-side and SPI-side signals of the single-byte SPI transmitter
interface spi_master_tx_if;
    logic       spi_start;
    logic [7:0] spi_data;
    logic       spi_done;
    logic       sck;
    logic       cs;
    logic       mosi;

    modport master (
        input  spi_start,
        input  spi_data,
        output spi_done,
        output sck,
        output cs,
        output mosi
    );

    modport slave (
        output spi_start,
        output spi_data,
        input  spi_done,
        input  sck,
        input  cs,
        input  mosi
    );
endinterface

// File: rtl/spi_master_tx.sv
// rtl/spi_master_tx.sv - mode-0 MSB-first single-byte SPI master transmitter
// rst_n is asynchronous and active-high despite its name.
module spi_master_tx #(
    parameter int HALF_DIV = 4
) (
    input  logic            clk_50m,
    input  logic            rst_n,
    spi_master_tx_if.master bus
);

    localparam int CW = $clog2(HALF_DIV) + 1;
    localparam logic [CW-1:0] LAST = CW'(HALF_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_bit_cnt;
    logic [7:0]    r_shift;
    logic          r_sck;
    logic          r_cs;
    logic          r_mosi;
    logic          r_done;
    logic          w_half_end;

    assign w_half_end = (r_cnt == LAST);

    assign bus.sck      = r_sck;
    assign bus.cs       = r_cs;
    assign bus.mosi     = r_mosi;
    assign bus.spi_done = r_done;

    always_ff @(posedge clk_50m or posedge rst_n) begin
        if (rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_sck     <= 1'b0;
            r_cs      <= 1'b1;
            r_mosi    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_cs   <= 1'b1;
                    r_sck  <= 1'b0;
                    r_mosi <= 1'b0;
                    if (bus.spi_start) begin
                        r_shift   <= bus.spi_data;
                        r_cs      <= 1'b0;
                        r_mosi    <= bus.spi_data[7];
                        r_cnt     <= '0;
                        r_bit_cnt <= '0;
                        r_state   <= SETUP;
                    end
                end

                SETUP: begin
                    if (w_half_end) begin
                        r_cnt     <= '0;
                        r_sck     <= 1'b1;
                        r_bit_cnt <= 4'd1;
                        r_state   <= SHIFT;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end

                SHIFT: begin
                    if (w_half_end) begin
                        r_cnt <= '0;
                        if (r_sck) begin
                            // Falling edge: present the next bit, or finish after the 8th rise.
                            r_sck <= 1'b0;
                            if (r_bit_cnt == 4'd8) begin
                                r_state <= HOLD;
                            end else begin
                                r_mosi  <= r_shift[6];
                                r_shift <= {r_shift[6:0], 1'b0};
                            end
                        end else begin
                            r_sck     <= 1'b1;
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end

                HOLD: begin
                    if (w_half_end) begin
                        r_cnt   <= '0;
                        r_cs    <= 1'b1;
                        r_mosi  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_tx.sv
// tb/tb_spi_master_tx.sv - scoreboard bench for spi_master_tx at HALF_DIV 4 and 1
module tb_spi_master_tx;

    logic clk_50m = 1'b0;
    logic rst_n   = 1'b1;

    always #5 clk_50m = ~clk_50m;

    spi_master_tx_if if4 ();
    spi_master_tx_if if1 ();

    spi_master_tx #(.HALF_DIV(4)) u_dut4 (
        .clk_50m (clk_50m),
        .rst_n   (rst_n),
        .bus     (if4.master)
    );

    spi_master_tx #(.HALF_DIV(1)) u_dut1 (
        .clk_50m (clk_50m),
        .rst_n   (rst_n),
        .bus     (if1.master)
    );

    typedef struct {
        logic [7:0] data;
        int         e0;
        int         lat;
    } exp_t;

    typedef struct {
        int         ch;
        logic [7:0] data;
        int         lat;
        int         gap;
    } vec_t;

    exp_t q0[$];
    exp_t q1[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk_50m) cyc <= cyc + 1;

    logic [1:0] w_sck, w_cs, w_mosi, w_done;
    assign w_sck  = {if1.sck,      if4.sck};
    assign w_cs   = {if1.cs,       if4.cs};
    assign w_mosi = {if1.mosi,     if4.mosi};
    assign w_done = {if1.spi_done, if4.spi_done};

    function automatic int half(input int ch);
        return (ch == 0) ? 4 : 1;
    endfunction

    task automatic chk(input string name, input int ch, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s ch%0d actual %0d required %0d at cycle %0d", name, ch, act, exp, cyc);
        end
    endtask

    logic [1:0] prev_sck  = 2'b00;
    logic [1:0] prev_cs   = 2'b11;
    logic [1:0] prev_done = 2'b00;
    logic [7:0] cap[2];
    int         rises[2];
    int         dones[2];
    exp_t       m_e;
    logic       m_have;

    initial begin
        for (int c = 0; c < 2; c++) begin
            cap[c]   = 8'h00;
            rises[c] = 0;
            dones[c] = 0;
        end
    end

    always @(negedge clk_50m) begin
        for (int c = 0; c < 2; c++) begin
            m_have = (c == 0) ? (q0.size() > 0) : (q1.size() > 0);
            if (m_have) m_e = (c == 0) ? q0[0] : q1[0];
            if (prev_cs[c] && !w_cs[c]) begin
                rises[c] = 0;
                cap[c]   = 8'h00;
            end
            chk("sck_high_with_cs_high", c, w_sck[c] & w_cs[c], 0);
            if (!prev_sck[c] && w_sck[c]) begin
                rises[c] = rises[c] + 1;
                cap[c]   = {cap[c][6:0], w_mosi[c]};
                if (m_have) chk("rise_time", c, cyc - m_e.e0, (2 * rises[c] - 1) * half(c));
            end
            if (w_done[c]) begin
                dones[c] = dones[c] + 1;
                chk("done_width", c, prev_done[c], 0);
                chk("cs_with_done", c, w_cs[c], 1);
                chk("done_expected", c, m_have, 1);
                if (m_have) begin
                    chk("byte", c, cap[c], m_e.data);
                    chk("rise_count", c, rises[c], 8);
                    chk("latency", c, cyc - m_e.e0, m_e.lat);
                    if (c == 0) void'(q0.pop_front());
                    else        void'(q1.pop_front());
                end
            end
        end
        prev_sck  = w_sck;
        prev_cs   = w_cs;
        prev_done = w_done;
    end

    task automatic send(input int ch, input logic [7:0] d, input int lat, output int e0);
        @(negedge clk_50m);
        e0 = cyc + 1;
        if (ch == 0) begin
            if4.spi_start = 1'b1;
            if4.spi_data  = d;
            q0.push_back('{data: d, e0: e0, lat: lat});
        end else begin
            if1.spi_start = 1'b1;
            if1.spi_data  = d;
            q1.push_back('{data: d, e0: e0, lat: lat});
        end
        @(negedge clk_50m);
        if (ch == 0) begin
            if4.spi_start = 1'b0;
            if4.spi_data  = ~d;
        end else begin
            if1.spi_start = 1'b0;
            if1.spi_data  = ~d;
        end
    endtask

    task automatic wait_idle(input int ch);
        int n;
        for (int k = 0; k < 400; k++) begin
            n = (ch == 0) ? q0.size() : q1.size();
            if (n == 0) break;
            @(negedge clk_50m);
        end
        n = (ch == 0) ? q0.size() : q1.size();
        chk("frame_completed", ch, n, 0);
        if (ch == 0) q0.delete();
        else         q1.delete();
    endtask

    task automatic chk_idle(input string name);
        for (int c = 0; c < 2; c++) begin
            chk({name, "_cs"},   c, w_cs[c],   1);
            chk({name, "_sck"},  c, w_sck[c],  0);
            chk({name, "_mosi"}, c, w_mosi[c], 0);
            chk({name, "_done"}, c, w_done[c], 0);
        end
    endtask

    vec_t vt[$];
    int   e0;
    int   d_before;

    initial begin
        if4.spi_start = 1'b0;
        if4.spi_data  = 8'h00;
        if1.spi_start = 1'b0;
        if1.spi_data  = 8'h00;

        vt.push_back('{ch: 0, data: 8'hAA, lat: 68, gap: 5});
        vt.push_back('{ch: 1, data: 8'hFF, lat: 17, gap: 5});
        vt.push_back('{ch: 1, data: 8'h00, lat: 17, gap: 5});
        vt.push_back('{ch: 1, data: 8'h81, lat: 17, gap: 5});
        vt.push_back('{ch: 0, data: 8'h5A, lat: 68, gap: 5});
        vt.push_back('{ch: 1, data: 8'h3C, lat: 17, gap: 5});

        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk_50m);
            chk_idle("in_reset");
        end
        rst_n = 1'b0;
        repeat (20) begin
            @(negedge clk_50m);
            chk_idle("after_reset");
        end

        for (int i = 0; i < vt.size(); i++) begin
            send(vt[i].ch, vt[i].data, vt[i].lat, e0);
            wait_idle(vt[i].ch);
            repeat (vt[i].gap) @(negedge clk_50m);
        end

        for (int r = 0; r < 3; r++) begin
            send(0, 8'hC3, 68, e0);
            wait_idle(0);
            repeat (500) @(negedge clk_50m);
            chk("gap_cs",  0, if4.cs,  1);
            chk("gap_sck", 0, if4.sck, 0);
        end

        // Start accepted in the done cycle itself.
        send(1, 8'h96, 17, e0);
        for (int k = 0; k < 100 && !if1.spi_done; k++) @(negedge clk_50m);
        chk("b2b_done_seen", 1, if1.spi_done, 1);
        chk("b2b_cs_high_in_done", 1, if1.cs, 1);
        if1.spi_start = 1'b1;
        if1.spi_data  = 8'h69;
        q1.push_back('{data: 8'h69, e0: cyc + 1, lat: 17});
        @(negedge clk_50m);
        if1.spi_start = 1'b0;
        if1.spi_data  = 8'h00;
        chk("b2b_accept", 1, if1.cs, 0);
        wait_idle(1);

        // Start while busy is ignored.
        d_before = dones[0];
        send(0, 8'hE1, 68, e0);
        while (cyc < e0 + 19) @(negedge clk_50m);
        if4.spi_start = 1'b1;
        if4.spi_data  = 8'h1E;
        @(negedge clk_50m);
        if4.spi_start = 1'b0;
        wait_idle(0);
        repeat (40) @(negedge clk_50m);
        chk("busy_one_done", 0, dones[0] - d_before, 1);

        // Asynchronous reset mid-frame.
        send(0, 8'h77, 68, e0);
        while (cyc < e0 + 29) @(negedge clk_50m);
        @(posedge clk_50m);
        #1;
        chk("pre_reset_sck", 0, if4.sck, 1);
        rst_n = 1'b1;
        #1;
        chk("async_cs",   0, if4.cs,   1);
        chk("async_sck",  0, if4.sck,  0);
        chk("async_mosi", 0, if4.mosi, 0);
        q0.delete();
        d_before = dones[0];
        repeat (5) @(negedge clk_50m);
        rst_n = 1'b0;
        repeat (80) @(negedge clk_50m);
        chk("no_done_after_abort", 0, dones[0] - d_before, 0);
        send(0, 8'hB4, 68, e0);
        wait_idle(0);
        repeat (5) @(negedge clk_50m);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_master_tx.md
# spi_master_tx

Single-byte SPI master transmitter, SPI mode 0 (CPOL=0, CPHA=0), MSB first, write-only. It sits between on-chip control logic running on the 50 MHz system clock and an external SPI slave such as a DAC or display. A one-cycle start pulse launches one 8-bit frame framed by an active-low chip select. A one-cycle done pulse marks frame completion.

## Interface
Parameters:
- HALF_DIV, default 4: SCK half-period in clk_50m cycles; legal ≥1. Default gives SCK = 6.25 MHz.

Ports (clock and reset first):
- clk_50m  input  1  system clock; all logic is on its rising edge.
- rst_n  input  1  reset. Asynchronous, active-high: asserted when 1, despite the name.
- spi_start  input  1  one-cycle request; samples spi_data.
- spi_data  input  8  byte to transmit; sampled only on the accepting edge.
- spi_done  output  1  one-cycle pulse at end of frame.
- sck  output  1  SPI clock; idles low.
- cs  output  1  chip select, active low; idles high.
- mosi  output  1  serial data, MSB first.

## Operation
- All outputs are registered.
- Reset values: cs=1, sck=0, mosi=0, spi_done=0. Internal state returns to IDLE.
- States and transitions:
  - IDLE → SETUP on spi_start=1.
  - SETUP → SHIFT after HALF_DIV cycles.
  - SHIFT → HOLD after 16 SCK half-periods.
  - HOLD → IDLE after HALF_DIV cycles.
- IDLE: cs=1, sck=0, mosi=0. When spi_start=1:
  - load shift register with spi_data;
  - cs<=0; mosi<=spi_data[7];
  - clear the half-period counter and bit counter.
- SETUP: hold cs low and sck low for HALF_DIV cycles (data setup), then sck<=1. This is the first rising edge.
- SHIFT: sck toggles every HALF_DIV cycles.
  - On each falling toggle, except after the 8th bit, mosi<=next lower bit.
  - The slave samples on rising SCK edges; data is stable for the full high phase.
  - After the 8th rising edge, the next toggle drives sck<=0 and enters HOLD.
- HOLD: sck=0, mosi holds bit 0, cs stays low for HALF_DIV cycles. Then cs<=1, mosi<=0, spi_done<=1 for exactly one cycle, and return to IDLE.
- spi_start is ignored in SETUP/SHIFT/HOLD; no queuing. spi_data changes during a frame have no effect.
- The cycle in which spi_done=1 is an IDLE cycle: a spi_start there is accepted, so cs is high for one cycle minimum between frames.
- Reset mid-frame aborts at once: outputs take reset values and no spi_done is issued.
- Counters: half-period counter ⌈log2(HALF_DIV)⌉+1 bits; bit counter 4 bits. No wrap is observable outside a frame.

## Timing
Let E0 be the clk_50m edge that samples spi_start=1 in IDLE; H = HALF_DIV.
- After E0: cs=0, mosi=spi_data[7].
- Rising SCK edge n (n=1..8) occurs at edge E0+(2n−1)H. Falling edge n occurs at E0+2nH.
- mosi changes to bit 7−n at E0+2nH, for n=1..7.
- Last falling SCK edge: E0+16H.
- cs=1 and spi_done=1 after edge E0+17H. spi_done deasserts after E0+17H+1.
- Frame latency, start to done: 17H cycles. With H=4: 68 cycles.
- SCK duty is exactly 50%, with exactly 8 rising edges per frame.
- SCK is never high while cs=1.

## Test plan
- Reset: hold rst_n=1 for 10 cycles, then release. Required: cs=1, sck=0, mosi=0, spi_done=0 throughout and after, with no activity.
- Single frame, spi_data=8'b10101010, H=4, start pulse: cs falls after E0. The bits captured on the 8 sck rises are 1,0,1,0,1,0,1,0. Rises land at E0+4, 12, …, 60. spi_done is a single-cycle pulse at E0+68, together with cs rising.
- Patterns 8'hFF, 8'h00, 8'h81 with H=1: correct MSB-first bits, 8 sck rises, spi_done at E0+17.
- Repeated frames: start pulse 500 cycles after each spi_done, repeated 3 times. Each frame is identical; cs stays high and sck low between frames.
- Start while busy: spi_start with a different spi_data at E0+20. Required: ignored, the original byte is still sent, and exactly one spi_done pulse occurs.
- Reset mid-frame: assert rst_n at E0+30. Required: cs=1, sck=0, mosi=0 immediately (asynchronous) and no spi_done. After release, a new start produces a complete correct frame.
